mem_stage: RTL

- Memory-access pipeline stage directly downstream of the EX/MEM pipeline register.
- Consumes the registered EX result and performs the load/store on the data bus:
  - alignment check
  - byte-strobe generation
  - load extraction with sign/zero extension
- Presents a registered result to the WB stage through the same ls_valid/ts_ready/ns_ready/ts_valid handshake used across the pipeline.

---
 rtl/lsu_pkg.sv | 29 ++
 rtl/lsu_align.sv | 45 ++++
 rtl/mem_stage.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared LSU encodings for the memory stage: lsu_op field layout, access sizes,
// the misaligned-access exception bit and the memory-stage state enum.
package lsu_pkg;

    // lsu_op bit positions
    localparam int unsigned LSU_MEM      = 4;
    localparam int unsigned LSU_STORE    = 3;
    localparam int unsigned LSU_UNSIGNED = 2;
    localparam int unsigned LSU_SIZE_HI  = 1;
    localparam int unsigned LSU_SIZE_LO  = 0;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    localparam logic [4:0] LSU_OP_INVALID = 5'd0;

    localparam int unsigned EXC_ALE  = 9;
    localparam logic [31:0] ALE_MASK = 32'd1 << EXC_ALE;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        DONE,
        DRAIN
    } mem_state_e;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: store strobes and lane replication, load extraction with
// sign/zero extension, and the misaligned-access flag.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [31:0] sdata,
    input  logic [31:0] rdata,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata,
    output logic [31:0] ldata,
    output logic        misalign
);

    logic [31:0] shifted;

    assign shifted = rdata >> {addr_lo, 3'b000};

    always_comb begin
        wstrb    = 4'b1111;
        wdata    = sdata;
        ldata    = shifted;
        misalign = 1'b0;
        case (size)
            SIZE_B: begin
                wstrb = 4'b0001 << addr_lo;
                wdata = {4{sdata[7:0]}};
                ldata = is_unsigned ? {24'd0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
            end
            SIZE_H: begin
                wstrb    = 4'b0011 << addr_lo;
                wdata    = {2{sdata[15:0]}};
                ldata    = is_unsigned ? {16'd0, shifted[15:0]}
                                       : {{16{shifted[15]}}, shifted[15:0]};
                misalign = addr_lo[0];
            end
            default: begin
                misalign = |addr_lo;
            end
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage between EX/MEM and WB: issues loads/stores on the data bus
// and registers the result for WB. Optional perf counters under MEM_PERF_CNT_EN.
module mem_stage
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ls_valid,
    output logic              ts_ready,
    input  logic              ns_ready,
    output logic              ts_valid,
    input  logic              flush,
    input  logic              stall,
    input  logic [31:0]       in_pc,
    input  logic [31:0]       in_inst,
    input  logic [DATA_W-1:0] in_ex_result,
    input  logic              in_rw_en,
    input  logic [4:0]        in_rw_addr,
    input  logic [DATA_W-1:0] in_lsu_data,
    input  logic [4:0]        in_lsu_op,
    input  logic [31:0]       in_except_type,
    output logic              dreq_valid,
    input  logic              dreq_ready,
    output logic              dreq_we,
    output logic [ADDR_W-1:0] dreq_addr,
    output logic [3:0]        dreq_wstrb,
    output logic [DATA_W-1:0] dreq_wdata,
    input  logic              dresp_valid,
    input  logic [DATA_W-1:0] dresp_rdata,
    output logic [31:0]       wb_pc,
    output logic [31:0]       wb_inst,
    output logic              wb_rw_en,
    output logic [4:0]        wb_rw_addr,
    output logic [DATA_W-1:0] wb_rw_data,
    output logic [31:0]       wb_except_type,
    output logic [ADDR_W-1:0] wb_badv
`ifdef MEM_PERF_CNT_EN
    ,
    output logic [31:0]       perf_load_cnt,
    output logic [31:0]       perf_store_cnt,
    output logic [31:0]       perf_wait_cyc
`endif
);

    mem_state_e state_q, state_d;
    logic out_valid_q, out_valid_d;
    logic [DATA_W-1:0] hold_data_q, hold_data_d;

    logic [31:0]       req_pc_q, req_inst_q;
    logic              req_rw_en_q;
    logic [4:0]        req_rw_addr_q;
    logic [ADDR_W-1:0] req_addr_q;
    logic [3:0]        req_op_q;
    logic [DATA_W-1:0] req_sdata_q;

    logic free, accept, in_mem, in_exc, in_ale, start_mem, direct_wb, hold_wb;
    logic handshake, req_store;

    logic [1:0]        al_addr, al_size;
    logic              al_unsigned;
    logic [DATA_W-1:0] al_sdata, al_wdata, al_ldata;
    logic [3:0]        al_wstrb;
    logic              al_misalign;

    // In IDLE the lane logic checks the incoming op; afterwards it serves the latched one.
    always_comb begin
        if (state_q == IDLE) begin
            al_addr     = in_ex_result[1:0];
            al_size     = in_lsu_op[LSU_SIZE_HI:LSU_SIZE_LO];
            al_unsigned = in_lsu_op[LSU_UNSIGNED];
            al_sdata    = in_lsu_data;
        end else begin
            al_addr     = req_addr_q[1:0];
            al_size     = req_op_q[LSU_SIZE_HI:LSU_SIZE_LO];
            al_unsigned = req_op_q[LSU_UNSIGNED];
            al_sdata    = req_sdata_q;
        end
    end

    lsu_align u_align (
        .addr_lo     (al_addr),
        .size        (al_size),
        .is_unsigned (al_unsigned),
        .sdata       (al_sdata),
        .rdata       (dresp_rdata),
        .wstrb       (al_wstrb),
        .wdata       (al_wdata),
        .ldata       (al_ldata),
        .misalign    (al_misalign)
    );

    assign free      = !out_valid_q || (ns_ready && !stall);
    assign accept    = ls_valid && ts_ready && !flush;
    assign in_mem    = in_lsu_op[LSU_MEM];
    assign in_exc    = |in_except_type;
    assign in_ale    = in_mem && !in_exc && al_misalign;
    assign start_mem = accept && in_mem && !in_exc && !al_misalign;
    assign direct_wb = accept && !start_mem;
    assign handshake = (state_q == REQ) && dreq_ready;
    assign req_store = req_op_q[LSU_STORE];
    assign hold_wb   = (state_q == DONE) && free && !flush;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (start_mem) state_d = REQ;
            REQ: begin
                if (handshake) begin
                    if (req_store) state_d = flush ? IDLE : DONE;
                    else           state_d = flush ? DRAIN : WAIT;
                end else if (flush) begin
                    state_d = IDLE;
                end
            end
            // A response coinciding with flush has already been consumed.
            WAIT: begin
                if (flush)            state_d = dresp_valid ? IDLE : DRAIN;
                else if (dresp_valid) state_d = DONE;
            end
            DONE:  if (flush || free) state_d = IDLE;
            DRAIN: if (dresp_valid)   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ts_valid   = out_valid_q && !stall;
        ts_ready   = (state_q == IDLE) && free && !stall;
        // Withdrawal is allowed only on flush, and never once the bus has accepted.
        dreq_valid = (state_q == REQ) && (!flush || dreq_ready);
        dreq_we    = req_store;
        dreq_addr  = {req_addr_q[ADDR_W-1:2], 2'b00};
        dreq_wstrb = al_wstrb;
        dreq_wdata = al_wdata;

        out_valid_d = out_valid_q;
        if (flush)                      out_valid_d = 1'b0;
        else if (direct_wb || hold_wb)  out_valid_d = 1'b1;
        else if (ns_ready && !stall)    out_valid_d = 1'b0;

        hold_data_d = hold_data_q;
        if (handshake && req_store)             hold_data_d = '0;
        else if (state_q == WAIT && dresp_valid) hold_data_d = al_ldata;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q        <= IDLE;
            out_valid_q    <= 1'b0;
            hold_data_q    <= '0;
            req_pc_q       <= '0;
            req_inst_q     <= '0;
            req_rw_en_q    <= 1'b0;
            req_rw_addr_q  <= '0;
            req_addr_q     <= '0;
            req_op_q       <= '0;
            req_sdata_q    <= '0;
            wb_pc          <= '0;
            wb_inst        <= '0;
            wb_rw_en       <= 1'b0;
            wb_rw_addr     <= '0;
            wb_rw_data     <= '0;
            wb_except_type <= '0;
            wb_badv        <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            hold_data_q <= hold_data_d;
            if (start_mem) begin
                req_pc_q      <= in_pc;
                req_inst_q    <= in_inst;
                req_rw_en_q   <= in_rw_en;
                req_rw_addr_q <= in_rw_addr;
                req_addr_q    <= in_ex_result[ADDR_W-1:0];
                req_op_q      <= in_lsu_op[3:0];
                req_sdata_q   <= in_lsu_data;
            end
            if (direct_wb) begin
                wb_pc          <= in_pc;
                wb_inst        <= in_inst;
                wb_rw_en       <= in_rw_en && !in_exc && !in_ale;
                wb_rw_addr     <= in_rw_addr;
                wb_rw_data     <= in_ex_result;
                wb_except_type <= in_except_type | (in_ale ? ALE_MASK : 32'd0);
                wb_badv        <= in_ale ? in_ex_result[ADDR_W-1:0] : '0;
            end else if (hold_wb) begin
                wb_pc          <= req_pc_q;
                wb_inst        <= req_inst_q;
                wb_rw_en       <= req_rw_en_q;
                wb_rw_addr     <= req_rw_addr_q;
                wb_rw_data     <= hold_data_q;
                wb_except_type <= '0;
                wb_badv        <= '0;
            end
        end
    end

`ifdef MEM_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            perf_load_cnt  <= '0;
            perf_store_cnt <= '0;
            perf_wait_cyc  <= '0;
        end else begin
            if (handshake && !req_store) perf_load_cnt  <= perf_load_cnt + 32'd1;
            if (handshake && req_store)  perf_store_cnt <= perf_store_cnt + 32'd1;
            if (state_q == REQ || state_q == WAIT || state_q == DRAIN) begin
                perf_wait_cyc <= perf_wait_cyc + 32'd1;
            end
        end
    end
`endif

endmodule
